// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response
// channel, and the decode-side head-of-queue handshake.
interface fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    // Fetch-queue side.
    modport master (
        input  redirect_valid, redirect_pc,
        output im_req, im_addr,
        input  im_ready, im_rvalid, im_rdata,
        output id_valid, id_inst, id_pc,
        input  id_ready
    );

    // Environment side: memory, EX redirect source, and decode.
    modport slave (
        output redirect_valid, redirect_pc,
        input  im_req, im_addr,
        output im_ready, im_rvalid, im_rdata,
        input  id_valid, id_inst, id_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential instruction-memory reads, keeps
// fetched {pc, inst} pairs in a small FIFO for decode, and on a redirect
// flushes the FIFO and discards responses to requests already in flight.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic [CW:0]   occupancy;
    logic          accept;
    logic          resp;
    logic          drop;
    logic          push;
    logic          pop;

    // Request gating reserves a FIFO slot for every in-flight request, so a
    // push can never hit a full FIFO; redirect suppresses push, pop and request.
    always_comb begin
        occupancy    = {1'b0, count} + {1'b0, inflight};
        bus.im_req   = rst_n & ~bus.redirect_valid & (occupancy < DEPTH_L);
        bus.im_addr  = fetch_pc;
        bus.id_valid = (count != '0);
        bus.id_inst  = mem_inst[rd_ptr];
        bus.id_pc    = mem_pc[rd_ptr];
        accept       = bus.im_req & bus.im_ready;
        resp         = bus.im_rvalid;
        drop         = resp & (drop_cnt != '0);
        push         = resp & ~drop & ~bus.redirect_valid;
        pop          = bus.id_valid & bus.id_ready & ~bus.redirect_valid;
    end

    // Control state: PCs, in-flight/stale accounting, FIFO pointers and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.redirect_valid) begin
            // Every request still unanswered after this cycle becomes stale.
            fetch_pc <= bus.redirect_pc;
            rsp_pc   <= bus.redirect_pc;
            inflight <= inflight - CW'(resp);
            drop_cnt <= inflight - CW'(resp);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CW'(accept) - CW'(resp);
            if (drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= rsp_pc;
            mem_inst[wr_ptr] <= bus.im_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an in-order memory model answers accepted
// requests one cycle later; expected outputs per cycle are hand-computed.
module tb_fetch_queue;
    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] pending[$];

    typedef struct {
        logic        rst;
        logic        idr;
        logic        ren;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance memory model.
    task automatic cyc(input logic idr, input logic ren, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] epc, input string lbl);
        logic        acc;
        logic        rv;
        logic [31:0] a;
        @(negedge clk);
        bus.id_ready       = idr;
        bus.im_ready       = rdy;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        if (ren && pending.size() > 0) begin
            bus.im_rvalid = 1'b1;
            bus.im_rdata  = pending[0] ^ KEY;
        end else begin
            bus.im_rvalid = 1'b0;
            bus.im_rdata  = '0;
        end
        #1;
        chk({lbl, ".im_req"}, 32'(bus.im_req), 32'(ereq));
        chk({lbl, ".im_addr"}, bus.im_addr, eaddr);
        chk({lbl, ".id_valid"}, 32'(bus.id_valid), 32'(evalid));
        if (evalid) begin
            chk({lbl, ".id_pc"}, bus.id_pc, epc);
            chk({lbl, ".id_inst"}, bus.id_inst, epc ^ KEY);
        end
        acc = bus.im_req & bus.im_ready;
        a   = bus.im_addr;
        rv  = bus.im_rvalid;
        @(posedge clk);
        if (rv) void'(pending.pop_front());
        if (acc) pending.push_back(a);
    endtask

    task automatic do_reset(input string lbl);
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.im_rvalid      = 1'b0;
        bus.im_rdata       = '0;
        bus.id_ready       = 1'b0;
        bus.im_ready       = 1'b1;
        pending.delete();
        #1;
        chk({lbl, ".rst_im_req"}, 32'(bus.im_req), 32'd0);
        chk({lbl, ".rst_im_addr"}, bus.im_addr, 32'h0);
        chk({lbl, ".rst_id_valid"}, 32'(bus.id_valid), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Streaming: id_ready=1, 1-cycle memory latency.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h4};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h8};
        // Decode stall fills the queue, single pop releases one request.
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h4};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h14, 1'b1, 32'h4};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h14, 1'b1, 32'h4};

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.im_ready       = 1'b1;
        bus.im_rvalid      = 1'b0;
        bus.im_rdata       = '0;
        bus.id_ready       = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) do_reset($sformatf("vec%0d", i));
            cyc(tbl[i].idr, tbl[i].ren, tbl[i].rdy, tbl[i].rd, tbl[i].rpc,
                tbl[i].ereq, tbl[i].eaddr, tbl[i].evalid, tbl[i].epc, $sformatf("vec%0d", i));
        end

        // im_ready low: request held, address does not advance.
        do_reset("stall");
        cyc(1, 1, 0, 0, 0, 1, 32'h0, 0, 0, "stall0");
        cyc(1, 1, 1, 0, 0, 1, 32'h0, 0, 0, "stall1");
        cyc(1, 1, 1, 0, 0, 1, 32'h4, 0, 0, "stall2");

        // Redirect with two requests in flight: both responses dropped.
        do_reset("redir2");
        cyc(1, 0, 1, 0, 0,        1, 32'h000, 0, 0,        "redir2_c0");
        cyc(1, 0, 1, 0, 0,        1, 32'h004, 0, 0,        "redir2_c1");
        cyc(1, 0, 1, 1, 32'h100,  0, 32'h008, 0, 0,        "redir2_c2");
        cyc(1, 1, 1, 0, 0,        1, 32'h100, 0, 0,        "redir2_c3");
        cyc(1, 1, 1, 0, 0,        1, 32'h104, 0, 0,        "redir2_c4");
        cyc(1, 1, 1, 0, 0,        1, 32'h108, 0, 0,        "redir2_c5");
        cyc(1, 1, 1, 0, 0,        1, 32'h10C, 1, 32'h100,  "redir2_c6");

        // Redirect coincident with the only response: no stale count left.
        do_reset("redir1");
        cyc(1, 1, 1, 0, 0,        1, 32'h000, 0, 0,        "redir1_c0");
        cyc(1, 1, 1, 1, 32'h200,  0, 32'h004, 0, 0,        "redir1_c1");
        cyc(1, 1, 1, 0, 0,        1, 32'h200, 0, 0,        "redir1_c2");
        cyc(1, 1, 1, 0, 0,        1, 32'h204, 0, 0,        "redir1_c3");
        cyc(1, 1, 1, 0, 0,        1, 32'h208, 1, 32'h200,  "redir1_c4");

        // Push and pop together at count=2: count holds, head advances.
        do_reset("pp");
        cyc(0, 1, 1, 0, 0, 1, 32'h00, 0, 0,     "pp_c0");
        cyc(0, 1, 1, 0, 0, 1, 32'h04, 0, 0,     "pp_c1");
        cyc(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h0, "pp_c2");
        cyc(1, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h0, "pp_c3");
        cyc(0, 1, 1, 0, 0, 1, 32'h10, 1, 32'h4, "pp_c4");
        cyc(0, 1, 1, 0, 0, 0, 32'h14, 1, 32'h4, "pp_c5");

        // Redirect to the top of the address space: PCs wrap to zero.
        do_reset("wrap");
        cyc(1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 0,             "wrap_c0");
        cyc(1, 1, 1, 0, 0,             1, 32'hFFFF_FFFC, 0, 0,             "wrap_c1");
        cyc(1, 1, 1, 0, 0,             1, 32'h0000_0000, 0, 0,             "wrap_c2");
        cyc(1, 1, 1, 0, 0,             1, 32'h0000_0004, 1, 32'hFFFF_FFFC, "wrap_c3");
        cyc(1, 1, 1, 0, 0,             1, 32'h0000_0008, 1, 32'h0000_0000, "wrap_c4");

        // Asynchronous reset mid-operation, away from any clock edge.
        @(negedge clk);
        #3 rst_n = 1'b0;
        pending.delete();
        #1;
        chk("midrst.im_req", 32'(bus.im_req), 32'd0);
        chk("midrst.im_addr", bus.im_addr, 32'h0);
        chk("midrst.id_valid", 32'(bus.id_valid), 32'd0);
        bus.im_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1, 1, 1, 0, 0, 1, 32'h0, 0, 0, "post_c0");
        cyc(1, 1, 1, 0, 0, 1, 32'h4, 0, 0, "post_c1");
        cyc(1, 1, 1, 0, 0, 1, 32'h8, 1, 32'h0, "post_c2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
